// File: rtl/cycle_extract.sv
// Scans vertmat for flagged vertices, walks each predecessor chain and streams
// the cycle out as vertex/weight beats, clearing the flag of every emitted vertex.
module cycle_extract #(
   parameter int unsigned NODES       = 128,
   parameter int unsigned PRED_BITS   = 8,
   parameter int unsigned WEIGHT_BITS = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   output logic [PRED_BITS-1:0]             vertmat_addr,
   input  logic [PRED_BITS+WEIGHT_BITS:0]   vertmat_q,
   output logic                             vertmat_we,
   output logic [PRED_BITS+WEIGHT_BITS:0]   vertmat_data,
   output logic [PRED_BITS-1:0]             out_vertex,
   output logic [WEIGHT_BITS-1:0]           out_weight,
   output logic                             out_last,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             busy,
   output logic                             done,
   output logic                             error
);

   localparam int unsigned ENTRY_BITS = 1 + PRED_BITS + WEIGHT_BITS;
   localparam int unsigned IDX_BITS   = (NODES > 1) ? $clog2(NODES) : 1;
   localparam logic [PRED_BITS-1:0] LAST_IDX = PRED_BITS'(NODES - 1);

   typedef enum logic [2:0] {
      IDLE, SCAN_RD, SCAN_CHK, WALK_RD, WALK_LAT, WALK_EMIT, DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [PRED_BITS-1:0]   idx_q, idx_d;
   logic [PRED_BITS-1:0]   cur_q, cur_d;
   logic [PRED_BITS-1:0]   pred_q, pred_d;
   logic [WEIGHT_BITS-1:0] weight_q, weight_d;
   logic                   last_q, last_d;
   logic                   error_q, error_d;
   logic [NODES-1:0]       visited_q, visited_d;

   logic                   q_flag;
   logic [PRED_BITS-1:0]   q_pred;
   logic [WEIGHT_BITS-1:0] q_weight;
   logic                   q_pred_ok;

   assign q_flag    = vertmat_q[ENTRY_BITS-1];
   assign q_pred    = vertmat_q[ENTRY_BITS-2 -: PRED_BITS];
   assign q_weight  = vertmat_q[WEIGHT_BITS-1:0];
   assign q_pred_ok = 32'(q_pred) < NODES;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cur_q     <= '0;
         pred_q    <= '0;
         weight_q  <= '0;
         last_q    <= 1'b0;
         error_q   <= 1'b0;
         visited_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cur_q     <= cur_d;
         pred_q    <= pred_d;
         weight_q  <= weight_d;
         last_q    <= last_d;
         error_q   <= error_d;
         visited_q <= visited_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cur_d        = cur_q;
      pred_d       = pred_q;
      weight_d     = weight_q;
      last_d       = last_q;
      error_d      = error_q;
      visited_d    = visited_q;
      vertmat_addr = '0;
      vertmat_we   = 1'b0;
      vertmat_data = '0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               visited_d = '0;
               error_d   = 1'b0;
               idx_d     = '0;
               state_d   = SCAN_RD;
            end
         end
         SCAN_RD: begin
            vertmat_addr = idx_q;
            state_d      = SCAN_CHK;
         end
         SCAN_CHK: begin
            vertmat_addr = idx_q;
            if (q_flag && !visited_q[IDX_BITS'(idx_q)]) begin
               cur_d   = idx_q;
               state_d = WALK_RD;
            end else if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + PRED_BITS'(1);
               state_d = SCAN_RD;
            end
         end
         WALK_RD: begin
            vertmat_addr = cur_q;
            state_d      = WALK_LAT;
         end
         WALK_LAT: begin
            // Chain closes on a vertex seen earlier this run (this or a prior walk)
            vertmat_addr = cur_q;
            pred_d       = q_pred;
            weight_d     = q_weight;
            visited_d[IDX_BITS'(cur_q)] = 1'b1;
            if (!q_pred_ok) begin
               error_d = 1'b1;
               last_d  = 1'b1;
            end else begin
               last_d = visited_q[IDX_BITS'(q_pred)] || (q_pred == cur_q);
            end
            state_d = WALK_EMIT;
         end
         WALK_EMIT: begin
            vertmat_addr = cur_q;
            if (out_ready && !reset) begin
               vertmat_we   = 1'b1;
               vertmat_data = {1'b0, pred_q, weight_q};
               if (!last_q) begin
                  cur_d   = pred_q;
                  state_d = WALK_RD;
               end else if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + PRED_BITS'(1);
                  state_d = SCAN_RD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_valid  = (state_q == WALK_EMIT);
   assign out_vertex = out_valid ? cur_q : '0;
   assign out_weight = out_valid ? weight_q : '0;
   assign out_last   = out_valid & last_q;
   assign busy       = (state_q != IDLE) && (state_q != DONE);
   assign done       = (state_q == DONE);
   assign error      = error_q;

endmodule

// File: tb/tb_cycle_extract.sv
// Directed bench for cycle_extract: small vertmat model, beat/write logging
// and hand-computed expectations for each graph.
module tb_cycle_extract;

   localparam int unsigned NODES = 8;
   localparam int unsigned PB    = 8;
   localparam int unsigned WB    = 32;
   localparam int unsigned EB    = 1 + PB + WB;

   logic          clk = 1'b0;
   logic          reset, start, out_ready;
   logic [PB-1:0] vertmat_addr;
   logic [EB-1:0] vertmat_q, vertmat_data;
   logic          vertmat_we;
   logic [PB-1:0] out_vertex;
   logic [WB-1:0] out_weight;
   logic          out_last, out_valid, busy, done, error;

   logic [EB-1:0] mem [0:NODES-1];
   logic          tb_we;
   logic [2:0]    tb_addr;
   logic [EB-1:0] tb_data;

   int            n_cmp = 0;
   int            n_err = 0;

   int            bq_v[$];
   logic [WB-1:0] bq_w[$];
   bit            bq_l[$];
   int            wq_a[$];
   logic [EB-1:0] wq_d[$];

   bit            rpat[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

   always #5 clk = ~clk;

   cycle_extract #(.NODES(NODES), .PRED_BITS(PB), .WEIGHT_BITS(WB)) dut (
      .clk(clk), .reset(reset), .start(start),
      .vertmat_addr(vertmat_addr), .vertmat_q(vertmat_q),
      .vertmat_we(vertmat_we), .vertmat_data(vertmat_data),
      .out_vertex(out_vertex), .out_weight(out_weight), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .error(error)
   );

   // Single-port synchronous RAM; bench preload port has priority
   always @(posedge clk) begin
      if (tb_we) mem[tb_addr] <= tb_data;
      else if (vertmat_we) mem[vertmat_addr[2:0]] <= vertmat_data;
      vertmat_q <= mem[vertmat_addr[2:0]];
   end

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         bq_v.push_back(int'(out_vertex));
         bq_w.push_back(out_weight);
         bq_l.push_back(out_last);
      end
      if (vertmat_we) begin
         wq_a.push_back(int'(vertmat_addr));
         wq_d.push_back(vertmat_data);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WB-1:0] wt(input int v);
      return WB'(32'hC0DE_0000 | v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int v, input bit f, input int p);
      tb_we   = 1'b1;
      tb_addr = 3'(v);
      tb_data = {f, PB'(p), wt(v)};
      tick();
      tb_we   = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < int'(NODES); i++) begin
         tb_we   = 1'b1;
         tb_addr = 3'(i);
         tb_data = '0;
         tick();
      end
      tb_we = 1'b0;
   endtask

   task automatic clear_q();
      bq_v.delete(); bq_w.delete(); bq_l.delete();
      wq_a.delete(); wq_d.delete();
   endtask

   // Pulse start and run to done; optionally drive ready from the stall pattern
   task automatic run(input string tag, input bit toggle, output int cycles);
      bit            pv, pr, sl;
      logic [PB-1:0] sv;
      logic [WB-1:0] sw;
      int            k;
      pv = 1'b0; pr = 1'b0; sl = 1'b0; sv = '0; sw = '0;
      start = 1'b1;
      for (k = 1; k <= 2000; k++) begin
         tick();
         start = 1'b0;
         if (toggle) out_ready = rpat[k % 4];
         @(negedge clk);
         if (k == 1) chk({tag, "_busy"}, 64'(busy), 64'd1);
         if (pv && !pr) begin
            chk({tag, "_stall_valid"},  64'(out_valid),  64'd1);
            chk({tag, "_stall_vertex"}, 64'(out_vertex), 64'(sv));
            chk({tag, "_stall_weight"}, 64'(out_weight), 64'(sw));
            chk({tag, "_stall_last"},   64'(out_last),   64'(sl));
         end
         pv = out_valid; pr = out_ready; sv = out_vertex; sw = out_weight; sl = out_last;
         if (done) break;
      end
      cycles = k;
      chk({tag, "_done"}, 64'(done), 64'd1);
      out_ready = 1'b1;
      tick();
   endtask

   task automatic expect_beats(input string tag, input int n, input int ev[3], input bit el[3]);
      chk({tag, "_nbeats"}, 64'(bq_v.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < bq_v.size()) begin
            chk({tag, "_vertex"}, 64'(bq_v[i]), 64'(ev[i]));
            chk({tag, "_weight"}, 64'(bq_w[i]), 64'(wt(ev[i])));
            chk({tag, "_last"},   64'(bq_l[i]), 64'(el[i]));
         end
      end
   endtask

   task automatic expect_writes(input string tag, input int n, input int ev[3], input int ep[3]);
      logic [EB-1:0] d;
      chk({tag, "_nwrites"}, 64'(wq_a.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < wq_a.size()) begin
            d = {1'b0, PB'(ep[i]), wt(ev[i])};
            chk({tag, "_waddr"}, 64'(wq_a[i]), 64'(ev[i]));
            chk({tag, "_wdata"}, 64'(wq_d[i]), 64'(d));
         end
      end
   endtask

   initial begin
      int cyc;
      reset = 1'b1; start = 1'b0; out_ready = 1'b1;
      tb_we = 1'b0; tb_addr = '0; tb_data = '0;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_busy",  64'(busy),      64'd0);
      chk("rst_done",  64'(done),      64'd0);
      chk("rst_error", 64'(error),     64'd0);
      chk("rst_we",    64'(vertmat_we), 64'd0);
      chk("rst_addr",  64'(vertmat_addr), 64'd0);
      tick();

      // Empty graph: done exactly 2*NODES+1 cycles after start
      clear_mem(); clear_q();
      run("empty", 1'b0, cyc);
      chk("empty_cycles", 64'(cyc), 64'd17);
      chk("empty_beats",  64'(bq_v.size()), 64'd0);
      chk("empty_writes", 64'(wq_a.size()), 64'd0);
      chk("empty_error",  64'(error), 64'd0);

      // Cycle 2 -> 5 -> 6 -> 2
      load(2, 1'b1, 5); load(5, 1'b1, 6); load(6, 1'b1, 2);
      clear_q();
      run("cyc", 1'b0, cyc);
      expect_beats("cyc", 3, '{2, 5, 6}, '{1'b0, 1'b0, 1'b1});
      expect_writes("cyc", 3, '{2, 5, 6}, '{5, 6, 2});
      chk("cyc_mem2", 64'(mem[2]), 64'({1'b0, 8'd5, wt(2)}));
      chk("cyc_mem6", 64'(mem[6]), 64'({1'b0, 8'd2, wt(6)}));

      // Same graph under back-pressure
      load(2, 1'b1, 5); load(5, 1'b1, 6); load(6, 1'b1, 2);
      clear_q();
      run("stall", 1'b1, cyc);
      expect_beats("stall", 3, '{2, 5, 6}, '{1'b0, 1'b0, 1'b1});
      expect_writes("stall", 3, '{2, 5, 6}, '{5, 6, 2});

      // Tail 1 -> 3 into cycle 3 <-> 4
      clear_mem();
      load(1, 1'b1, 3); load(3, 1'b1, 4); load(4, 1'b1, 3);
      clear_q();
      run("tail", 1'b0, cyc);
      expect_beats("tail", 3, '{1, 3, 4}, '{1'b0, 1'b0, 1'b1});
      chk("tail_error", 64'(error), 64'd0);

      // Out-of-range pred on 0, self-loop on 7
      clear_mem();
      load(0, 1'b1, 200); load(7, 1'b1, 7);
      clear_q();
      run("self", 1'b0, cyc);
      expect_beats("self", 2, '{0, 7, 0}, '{1'b1, 1'b1, 1'b0});
      expect_writes("self", 2, '{0, 7, 0}, '{200, 7, 0});
      chk("self_error", 64'(error), 64'd1);

      // Reset while stalled in the emit state
      clear_mem();
      load(2, 1'b1, 5); load(5, 1'b1, 6); load(6, 1'b1, 2);
      clear_q();
      out_ready = 1'b0;
      start = 1'b1;
      for (int k = 0; k < 100; k++) begin
         tick();
         start = 1'b0;
         @(negedge clk);
         if (out_valid) break;
      end
      chk("abort_valid_seen", 64'(out_valid), 64'd1);
      tick();
      reset = 1'b1;
      tick();
      @(negedge clk);
      chk("abort_valid",  64'(out_valid),  64'd0);
      chk("abort_we",     64'(vertmat_we), 64'd0);
      chk("abort_busy",   64'(busy),       64'd0);
      chk("abort_vertex", 64'(out_vertex), 64'd0);
      chk("abort_addr",   64'(vertmat_addr), 64'd0);
      chk("abort_nwrites", 64'(wq_a.size()), 64'd0);
      chk("abort_mem2",   64'(mem[2]), 64'({1'b1, 8'd5, wt(2)}));
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      tick();
      clear_q();
      run("rerun", 1'b0, cyc);
      expect_beats("rerun", 3, '{2, 5, 6}, '{1'b0, 1'b0, 1'b1});
      expect_writes("rerun", 3, '{2, 5, 6}, '{5, 6, 2});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
